// File: rtl/dm_access_arbiter.sv
// dm_access_arbiter: shares one single-port data memory between two requesters.
// Port 0 is the CPU load/store unit and port 1 is the DMA/debug loader.
// Arbitration is round-robin, and only one transaction is in flight at a time.
// Memory latency is fixed by a down-counter.
//
// Handshake (both ports): a requester raises reqN and holds it, with weN/addrN/wdataN,
// until ackN. The command is latched on the grant edge, and later changes are ignored.
// ackN is a one-cycle completion pulse. rdataN is valid with ackN and holds until
// the next read completes on the same port.
module dm_access_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int MEM_LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0,
    input  logic          we0,
    input  logic [AW-1:0] addr0,
    input  logic [DW-1:0] wdata0,
    output logic          ack0,
    output logic [DW-1:0] rdata0,
    input  logic          req1,
    input  logic          we1,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata1,
    output logic          ack1,
    output logic [DW-1:0] rdata1,
    output logic          mem_r,
    output logic          mem_wr,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy,
    output logic [1:0]    state_dbg
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);

    state_t        state;
    state_t        state_nx;
    logic          last_gnt;
    logic          gnt_q;
    logic          we_q;
    logic          first_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic [3:0]    cnt;
    logic          gnt_nx;
    logic          grant;

    // Arbitration: on a tie, grant the port that did not win last time.
    always_comb begin
        gnt_nx = 1'b0;
        if (req0 && req1) begin
            gnt_nx = ~last_gnt;
        end else if (req1) begin
            gnt_nx = 1'b1;
        end
        grant = (state == IDLE) && (req0 || req1);
    end

    // Next-state logic. DONE always returns to IDLE, so nothing is granted in the ack cycle.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (grant) state_nx = ACCESS;
            ACCESS:  if (cnt == 4'd0) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Latch the granted command, update the round-robin pointer and run the latency counter.
    // last_gnt resets to 1 so that port 0 wins the first tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_gnt <= 1'b1;
            gnt_q    <= 1'b0;
            we_q     <= 1'b0;
            first_q  <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            cnt      <= 4'd0;
        end else if (grant) begin
            gnt_q    <= gnt_nx;
            last_gnt <= gnt_nx;
            we_q     <= gnt_nx ? we1 : we0;
            addr_q   <= gnt_nx ? addr1 : addr0;
            wdata_q  <= gnt_nx ? wdata1 : wdata0;
            cnt      <= LAT_M1;
            first_q  <= 1'b1;
        end else if (state == ACCESS) begin
            first_q <= 1'b0;
            if (cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
        end
    end

    // Capture read data on the last ACCESS cycle. Writes never modify rdata.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata0 <= '0;
            rdata1 <= '0;
        end else if ((state == ACCESS) && (cnt == 4'd0) && !we_q) begin
            if (gnt_q) begin
                rdata1 <= mem_rdata;
            end else begin
                rdata0 <= mem_rdata;
            end
        end
    end

    // The strobes are decoded from registered state, so an async reset drops them at once.
    // mem_wr pulses only on the first ACCESS cycle, so the level-sensitive memory writes once.
    assign mem_r     = (state == ACCESS) && !we_q;
    assign mem_wr    = (state == ACCESS) && we_q && first_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign ack0      = (state == DONE) && !gnt_q;
    assign ack1      = (state == DONE) && gnt_q;
    assign busy      = (state != IDLE);
    assign state_dbg = state;

endmodule
